// File: rtl/mips_multicycle_ctrl_if.sv
// Handshake and strobe bundle between the multi-cycle sequencer and its datapath/SRAM side.
// master: the sequencer; slave: datapath, instruction and data SRAM.
interface mips_multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      inst_word;
    logic             halt;
    logic             inst_ack;
    logic             data_ack;
    logic             branch_taken;
    logic [5:0]       cur_state;
    logic             inst_req;
    logic             ir_wen;
    logic             pc_inc;
    logic             pc_redirect;
    logic             data_req;
    logic             data_we;
    logic             rf_wen;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;
    logic             timeout_err;

    modport master (
        input  inst_word, halt, inst_ack, data_ack, branch_taken,
        output cur_state, inst_req, ir_wen, pc_inc, pc_redirect,
               data_req, data_we, rf_wen, retire, retire_cnt, timeout_err
    );

    modport slave (
        output inst_word, halt, inst_ack, data_ack, branch_taken,
        input  cur_state, inst_req, ir_wen, pc_inc, pc_redirect,
               data_req, data_we, rf_wen, retire, retire_cnt, timeout_err
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// MIPS32 multi-cycle sequencer: IF/ID/EX/MEM/WB state register, instruction class decode,
// SRAM req/ack handshake, external halt, req-without-ack watchdog and retire counter.
module mips_multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    mips_multicycle_ctrl_if.master ctrl_bus
);

    typedef enum logic [5:0] {
        S_IF  = 6'b000001,
        S_ID  = 6'b000010,
        S_EX  = 6'b000100,
        S_MEM = 6'b001000,
        S_WB  = 6'b010000,
        S_ERR = 6'b100000
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_BR, C_J, C_JAL, C_JR, C_JALR, C_LD, C_ST
    } cls_t;

    localparam bit              WD_EN    = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(WD_EN ? TIMEOUT_CYC - 1 : 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TO_W-1:0]    r_wait;
    logic [TO_W-1:0]    w_wait_nxt;
    logic [CNT_W-1:0]   r_retire_cnt;
    cls_t               w_cls;
    logic [5:0]         w_op;
    logic [5:0]         w_funct;
    logic               w_waiting;
    logic               w_inst_req;
    logic               w_ir_wen;
    logic               w_pc_inc;
    logic               w_pc_redirect;
    logic               w_data_req;
    logic               w_data_we;
    logic               w_rf_wen;
    logic               w_retire;
    logic               w_unused;

    assign w_op     = ctrl_bus.inst_word[31:26];
    assign w_funct  = ctrl_bus.inst_word[5:0];
    assign w_unused = ^ctrl_bus.inst_word[25:6];

    // Control-flow class of the instruction held in IR
    always_comb begin
        w_cls = C_ALU;
        case (w_op)
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07:               w_cls = C_BR;
            6'h02:                                           w_cls = C_J;
            6'h03:                                           w_cls = C_JAL;
            6'h00: begin
                if (w_funct == 6'h08)      w_cls = C_JR;
                else if (w_funct == 6'h09) w_cls = C_JALR;
            end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: w_cls = C_LD;
            6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E:               w_cls = C_ST;
            default:                                         w_cls = C_ALU;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IF;
            r_wait       <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait       <= w_wait_nxt;
            if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    // Next state and phase strobes; w_waiting marks a cycle spent with a request unanswered
    always_comb begin
        w_state_nxt   = r_state;
        w_waiting     = 1'b0;
        w_inst_req    = 1'b0;
        w_ir_wen      = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_redirect = 1'b0;
        w_data_req    = 1'b0;
        w_data_we     = 1'b0;
        w_rf_wen      = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            S_IF: begin
                w_inst_req = ~ctrl_bus.halt;
                if (!ctrl_bus.halt) begin
                    if (ctrl_bus.inst_ack) begin
                        w_ir_wen    = 1'b1;
                        w_pc_inc    = 1'b1;
                        w_state_nxt = S_ID;
                    end else begin
                        w_waiting = 1'b1;
                    end
                end
            end
            S_ID: w_state_nxt = S_EX;
            S_EX: begin
                case (w_cls)
                    C_J, C_JR: begin
                        w_pc_redirect = 1'b1;
                        w_retire      = 1'b1;
                        w_state_nxt   = S_IF;
                    end
                    C_BR: begin
                        w_pc_redirect = ctrl_bus.branch_taken;
                        w_retire      = 1'b1;
                        w_state_nxt   = S_IF;
                    end
                    C_JAL, C_JALR: begin
                        w_pc_redirect = 1'b1;
                        w_state_nxt   = S_WB;
                    end
                    C_LD, C_ST: w_state_nxt = S_MEM;
                    default:    w_state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                w_data_req = 1'b1;
                w_data_we  = (w_cls == C_ST);
                if (ctrl_bus.data_ack) begin
                    if (w_cls == C_ST) begin
                        w_retire    = 1'b1;
                        w_state_nxt = S_IF;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else begin
                    w_waiting = 1'b1;
                end
            end
            S_WB: begin
                w_rf_wen    = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = S_IF;
            end
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_IF;
        endcase
        // An ack on the limit cycle clears w_waiting, so the normal transition wins
        if (WD_EN && w_waiting && (r_wait == WD_LIMIT)) begin
            w_state_nxt = S_ERR;
        end
    end

    // Watchdog counts consecutive unanswered request cycles within one state visit
    always_comb begin
        w_wait_nxt = r_wait;
        if ((w_state_nxt != r_state) || ((r_state == S_IF) && ctrl_bus.halt)) begin
            w_wait_nxt = '0;
        end else if (WD_EN && w_waiting) begin
            w_wait_nxt = r_wait + TO_W'(1);
        end
    end

    assign ctrl_bus.cur_state   = r_state;
    assign ctrl_bus.timeout_err = (r_state == S_ERR);
    assign ctrl_bus.retire_cnt  = r_retire_cnt;

    // Strobes are forced low while reset is held, independent of halt/ack inputs
    assign ctrl_bus.inst_req    = resetn & w_inst_req;
    assign ctrl_bus.ir_wen      = resetn & w_ir_wen;
    assign ctrl_bus.pc_inc      = resetn & w_pc_inc;
    assign ctrl_bus.pc_redirect = resetn & w_pc_redirect;
    assign ctrl_bus.data_req    = resetn & w_data_req;
    assign ctrl_bus.data_we     = resetn & w_data_we;
    assign ctrl_bus.rf_wen      = resetn & w_rf_wen;
    assign ctrl_bus.retire      = resetn & w_retire;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-accurate scoreboard bench for mips_multicycle_ctrl with a 4-cycle watchdog.
module tb_mips_multicycle_ctrl;

    localparam int unsigned TO    = 4;
    localparam int unsigned CNT_W = 32;

    localparam logic [5:0] S_IF  = 6'b000001;
    localparam logic [5:0] S_ID  = 6'b000010;
    localparam logic [5:0] S_EX  = 6'b000100;
    localparam logic [5:0] S_MEM = 6'b001000;
    localparam logic [5:0] S_WB  = 6'b010000;
    localparam logic [5:0] S_ERR = 6'b100000;

    // strobe vector order: inst_req ir_wen pc_inc pc_redirect data_req data_we rf_wen retire
    localparam logic [7:0] REQ = 8'h80;
    localparam logic [7:0] IRW = 8'h40;
    localparam logic [7:0] PCI = 8'h20;
    localparam logic [7:0] RED = 8'h10;
    localparam logic [7:0] DRQ = 8'h08;
    localparam logic [7:0] DWE = 8'h04;
    localparam logic [7:0] RFW = 8'h02;
    localparam logic [7:0] RET = 8'h01;
    localparam logic [7:0] NONE = 8'h00;

    localparam logic [31:0] I_ADDU = 32'h00851021;
    localparam logic [31:0] I_LW   = 32'h8C820004;
    localparam logic [31:0] I_SW   = 32'hAC820004;
    localparam logic [31:0] I_BEQ  = 32'h10850003;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_JR   = 32'h03E00008;

    typedef struct packed {
        logic [5:0]  st;
        logic [7:0]  strb;
        logic        terr;
        logic [31:0] cnt;
    } exp_t;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] cur_iw = 32'h0;
    logic [31:0] exp_cnt = 32'h0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mips_multicycle_ctrl #(
        .TIMEOUT_CYC(TO),
        .TO_W       (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .ctrl_bus(bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle of stimulus plus the expected outputs for that cycle
    task automatic cyc(input logic rst_n, input logic hlt, input logic iack, input logic dack,
                       input logic bt, input logic [5:0] st, input logic [7:0] strb);
        exp_t e;
        @(posedge clk);
        #1;
        resetn           = rst_n;
        bus.halt         = hlt;
        bus.inst_ack     = iack;
        bus.data_ack     = dack;
        bus.branch_taken = bt;
        bus.inst_word    = cur_iw;
        if (!rst_n) exp_cnt = 32'h0;
        e.st   = st;
        e.strb = strb;
        e.terr = (st == S_ERR);
        e.cnt  = exp_cnt;
        sb_q.push_back(e);
        if (strb[0]) exp_cnt = exp_cnt + 32'd1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_eq("cur_state", 64'(bus.cur_state), 64'(mon_e.st));
            check_eq("strobes", 64'({bus.inst_req, bus.ir_wen, bus.pc_inc, bus.pc_redirect,
                                     bus.data_req, bus.data_we, bus.rf_wen, bus.retire}),
                     64'(mon_e.strb));
            check_eq("timeout_err", 64'(bus.timeout_err), 64'(mon_e.terr));
            check_eq("retire_cnt", 64'(bus.retire_cnt), 64'(mon_e.cnt));
        end
    end

    task automatic fetch(input logic [31:0] iw, input int waits);
        for (int i = 0; i < waits; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IF, REQ);
        cur_iw = iw;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_IF, REQ | IRW | PCI);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_ID, NONE);
    endtask

    task automatic run_alu(input int waits);
        fetch(I_ADDU, waits);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EX, NONE);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_WB, RFW | RET);
    endtask

    initial begin
        bus.halt         = 1'b0;
        bus.inst_ack     = 1'b0;
        bus.data_ack     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.inst_word    = 32'h0;

        // reset state: IF, all strobes low even with halt=0
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IF, NONE);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_IF, NONE);

        // addu with ack one cycle after req
        run_alu(1);

        // lw with data_ack after 3 wait cycles (ack lands on the watchdog limit)
        fetch(I_LW, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EX, NONE);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_MEM, DRQ);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, S_MEM, DRQ);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_WB, RFW | RET);

        // sw
        fetch(I_SW, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EX, NONE);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, S_MEM, DRQ | DWE | RET);

        // beq taken, then not taken
        fetch(I_BEQ, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, S_EX, RED | RET);
        fetch(I_BEQ, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EX, RET);

        // jal, then jr
        fetch(I_JAL, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EX, RED);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_WB, RFW | RET);
        fetch(I_JR, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EX, RED | RET);

        // fetch watchdog: 4 unanswered cycles then ERR, held despite late acks
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IF, REQ);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, S_ERR, NONE);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IF, NONE);

        // ack on the 4th wait cycle beats the watchdog
        run_alu(3);

        // halt with ack present: no fetch, no timeout
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_IF, NONE);
        run_alu(0);

        // reset in the middle of a load abandons it
        fetch(I_LW, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EX, NONE);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_MEM, DRQ);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IF, NONE);
        run_alu(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IF, REQ);

        @(negedge clk);
        #1;
        check_eq("scoreboard_drain", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
